// File: rtl/cascade_counter_pkg.sv
// Shared types and constants for the cascaded modulo-M digit counter.
package cascade_counter_pkg;

  localparam int unsigned MOD_W           = 5;
  localparam int unsigned DEFAULT_DIGIT_W = 4;
  localparam int unsigned DEFAULT_DIGITS  = 4;

  // Digit 0 is the rightmost field: mm:ss as {min tens, min ones, sec tens, sec ones}.
  localparam logic [DEFAULT_DIGITS*MOD_W-1:0] DEFAULT_MODULI = {5'd6, 5'd10, 5'd6, 5'd10};

  typedef logic [DEFAULT_DIGIT_W-1:0] digit_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/mod_digit.sv
// Single modulo-MODULUS digit register with up/down step and clamped synchronous load.
module mod_digit
  import cascade_counter_pkg::*;
#(
  parameter int unsigned MODULUS = 10,
  parameter int unsigned DIGIT_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  dir_e               dir,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_val,
  output logic [DIGIT_W-1:0] q,
  output logic [DIGIT_W-1:0] q_next,
  output logic               term
);

  localparam logic [DIGIT_W-1:0] MaxVal = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] q_q, q_d;

  always_comb begin
    term = (dir == DIR_DOWN) ? (q_q == '0) : (q_q == MaxVal);
    q_d  = q_q;
    if (load) begin
      // Out-of-range load values collapse to zero so the digit stays legal.
      q_d = (32'(load_val) < MODULUS) ? load_val : '0;
    end else if (en) begin
      if (dir == DIR_UP) begin
        q_d = term ? '0 : q_q + 1'b1;
      end else begin
        q_d = term ? MaxVal : q_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign q_next = q_d;

endmodule

// File: rtl/cascade_mod_counter.sv
// Chain of modulo-M digits with same-edge carry propagation and registered terminal flags.
module cascade_mod_counter
  import cascade_counter_pkg::*;
#(
  parameter int unsigned                   NUM_DIGITS = DEFAULT_DIGITS,
  parameter int unsigned                   DIGIT_W    = DEFAULT_DIGIT_W,
  parameter logic [NUM_DIGITS*MOD_W-1:0]   MODULI     = DEFAULT_MODULI
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          carry_in,
  input  logic                          dir,
  input  logic                          load,
  input  logic [NUM_DIGITS*DIGIT_W-1:0] load_val,
  output logic [NUM_DIGITS*DIGIT_W-1:0] q,
  output logic                          carry_out,
  output logic                          is_zero,
  output logic                          is_max
);

  dir_e                          dir_sel;
  logic [NUM_DIGITS-1:0]         en;
  logic [NUM_DIGITS-1:0]         term;
  logic [NUM_DIGITS-1:0]         dig_max;
  logic [NUM_DIGITS*DIGIT_W-1:0] q_next;
  logic                          is_zero_q, is_zero_d;
  logic                          is_max_q, is_max_d;

  assign dir_sel = dir_e'(dir);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int unsigned Mod = int'(MODULI[i*MOD_W +: MOD_W]);

    if (Mod < 2 || Mod > 2**DIGIT_W) begin : g_bad_modulus
      $error("cascade_mod_counter: digit %0d modulus %0d out of range", i, Mod);
    end

    // Enable ripples combinationally from current state, so every digit moves on one edge.
    if (i == 0) begin : g_en_first
      assign en[i] = carry_in;
    end else begin : g_en_chain
      assign en[i] = en[i-1] & term[i-1];
    end

    mod_digit #(
      .MODULUS (Mod),
      .DIGIT_W (DIGIT_W)
    ) u_digit (
      .clk      (clk),
      .reset    (reset),
      .en       (en[i]),
      .dir      (dir_sel),
      .load     (load),
      .load_val (load_val[i*DIGIT_W +: DIGIT_W]),
      .q        (q[i*DIGIT_W +: DIGIT_W]),
      .q_next   (q_next[i*DIGIT_W +: DIGIT_W]),
      .term     (term[i])
    );

    assign dig_max[i] = (q_next[i*DIGIT_W +: DIGIT_W] == DIGIT_W'(Mod - 1));
  end

  assign carry_out = carry_in & ~reset & ~load & term[NUM_DIGITS-1] & en[NUM_DIGITS-1];

  always_comb begin
    is_zero_d = (q_next == '0);
    is_max_d  = &dig_max;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      is_zero_q <= 1'b1;
      is_max_q  <= 1'b0;
    end else begin
      is_zero_q <= is_zero_d;
      is_max_q  <= is_max_d;
    end
  end

  assign is_zero = is_zero_q;
  assign is_max  = is_max_q;

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Scoreboard bench for the default mm:ss configuration; model counts seconds modulo 3600.
module tb_cascade_mod_counter;
  import cascade_counter_pkg::*;

  logic        clk = 1'b0;
  logic        reset, carry_in, dir, load;
  logic [15:0] load_val;
  logic [15:0] q;
  logic        carry_out, is_zero, is_max;

  always #5 clk = ~clk;

  cascade_mod_counter #(
    .NUM_DIGITS (4),
    .DIGIT_W    (4),
    .MODULI     (DEFAULT_MODULI)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .carry_in  (carry_in),
    .dir       (dir),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .carry_out (carry_out),
    .is_zero   (is_zero),
    .is_max    (is_max)
  );

  typedef struct {
    string       tag;
    logic [15:0] q;
    logic        co;
    logic        zero;
    logic        max;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   checks = 0;
  int   errors = 0;

  // Model state: seconds since 00:00 plus the registered flags expected after the last edge.
  int   m_t    = 0;
  logic m_zero = 1'b1;
  logic m_max  = 1'b0;

  bit   win          = 1'b0;
  int   co_seen      = 0;
  bit   co_check_req = 1'b0;
  bit   co_check_done = 1'b0;

  function automatic logic [15:0] to_word(input int t);
    int mm = t / 60;
    int ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic int clamp_load(input logic [15:0] v);
    int d3 = int'(v[15:12]);
    int d2 = int'(v[11:8]);
    int d1 = int'(v[7:4]);
    int d0 = int'(v[3:0]);
    if (d3 >= 6)  d3 = 0;
    if (d2 >= 10) d2 = 0;
    if (d1 >= 6)  d1 = 0;
    if (d0 >= 10) d0 = 0;
    return (d3 * 10 + d2) * 60 + d1 * 10 + d0;
  endfunction

  task automatic cycle(input string tag, input logic rst, input logic ld, input logic cin,
                       input logic d, input logic [15:0] lv);
    exp_t e;
    int   nt;
    @(posedge clk);
    #1;
    reset    = rst;
    load     = ld;
    carry_in = cin;
    dir      = d;
    load_val = lv;
    e.tag  = tag;
    e.q    = to_word(m_t);
    e.zero = m_zero;
    e.max  = m_max;
    e.co   = cin && !rst && !ld && (d ? (m_t == 0) : (m_t == 3599));
    sb.push_back(e);
    if (rst)       nt = 0;
    else if (ld)   nt = clamp_load(lv);
    else if (cin)  nt = d ? (m_t + 3599) % 3600 : (m_t + 1) % 3600;
    else           nt = m_t;
    m_t    = nt;
    m_zero = (nt == 0);
    m_max  = (nt == 3599);
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      me = sb.pop_front();
      checks++;
      if ({q, carry_out, is_zero, is_max} !== {me.q, me.co, me.zero, me.max}) begin
        errors++;
        $display("FAIL %s: got q=%h co=%b zero=%b max=%b, want q=%h co=%b zero=%b max=%b",
                 me.tag, q, carry_out, is_zero, is_max, me.q, me.co, me.zero, me.max);
      end
      if (win && carry_out === 1'b1) co_seen++;
    end else if (co_check_req && !co_check_done) begin
      checks++;
      if (co_seen != 1) begin
        errors++;
        $display("FAIL wrap_count: got %0d carry_out pulses, want 1", co_seen);
      end
      co_check_done = 1'b1;
    end
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b1;
    carry_in = 1'b1;
    dir      = 1'b0;
    load_val = 16'h5959;

    cycle("reset0", 1'b1, 1'b1, 1'b1, 1'b0, 16'h5959);
    cycle("reset1", 1'b0, 1'b1, 1'b1, 1'b0, 16'h0959);
    cycle("step_0959", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cycle("hold_1000", 1'b0, 1'b1, 1'b1, 1'b0, 16'h5959);
    cycle("wrap_up", 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    cycle("after_wrap_up", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    cycle("after_wrap_dn", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    cycle("step_dn", 1'b0, 1'b1, 1'b1, 1'b0, 16'h7A34);
    cycle("show_5958", 1'b0, 1'b1, 1'b0, 1'b0, 16'h1000);
    cycle("clamp_7A34", 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    cycle("load_1000", 1'b0, 1'b1, 1'b1, 1'b0, 16'h6A6A);
    cycle("clamp_6A6A", 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    cycle("hold_no_cin", 1'b0, 1'b1, 1'b1, 1'b0, 16'h5959);
    cycle("load_beats_cin", 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234);
    cycle("reset_wins", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    win = 1'b1;
    for (int i = 0; i < 7200; i++) begin
      cycle("run_up", 1'b0, 1'b0, (i % 2 == 0), 1'b0, 16'h0000);
    end
    @(negedge clk);
    #1;
    win = 1'b0;
    co_check_req = 1'b1;
    for (int k = 0; k < 8 && !co_check_done; k++) @(negedge clk);
    #1;

    for (int i = 0; i < 400; i++) begin
      cycle("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom));
    end

    for (int k = 0; k < 8 && sb.size() != 0; k++) @(negedge clk);
    #1;
    if (sb.size() != 0 || !co_check_done) begin
      errors++;
      $display("FAIL drain: %0d entries left, wrap check done=%b, want 0 and 1",
               sb.size(), co_check_done);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
